dac_scan_driver: RTL and testbench
==================================

Name: dac_scan_driver

Overview:
Parametrised serial-DAC scan driver that replaces the fixed single-path DAC driver. It snapshots N_CH channel codes on a start request and emits one SPI-style frame per enabled channel on din/sync/clk_out. It supports single-sweep and continuous modes and drives the DAC supply enables vdd1/vdd2. It sits between the positioning control logic and the external multi-channel DAC.

Parameters:
N_CH, 4, number of DAC channels (1..4)
CODE_W, 12, DAC code width per channel
ADDR_W, 2, channel address field width in frame
CMD_BITS, 2'b01, command field sent after address (width 2)
CLK_DIV, 4, clk cycles per clk_out half-period (>=1)
GAP, 4, clk cycles sync held high between frames (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  sweep request, sampled only in IDLE
cont  in  1  1 = restart sweep automatically after done
ch_en  in  N_CH  per-channel enable; 0 = channel skipped
codes  in  N_CH*CODE_W  channel i code at [i*CODE_W +: CODE_W]
din  out  1  serial data, MSB first
sync  out  1  frame select, active-low
clk_out  out  1  serial clock, idles high
vdd1  out  1  DAC supply enable 1
vdd2  out  1  DAC supply enable 2
busy  out  1  high from sweep start to done
done  out  1  one-cycle pulse at sweep end
ch_idx  out  ADDR_W  channel currently being sent

Behaviour:
- Reset (async, rst_n=0): sync=1, clk_out=1, din=0, busy=0, done=0, ch_idx=0, vdd1=vdd2=0, state IDLE; a frame in progress aborts immediately, with no partial-frame completion.
- vdd1/vdd2: registered 1 from the first clk edge after rst_n rises; they stay 1 until reset.
- FRAME_W = ADDR_W+2+CODE_W (default 16). Frame = {ch index, CMD_BITS, code}, sent MSB first.
- States: IDLE, SETUP, SHIFT_LO, SHIFT_HI, GAP, DONE.
- IDLE: on start=1 at edge k, codes and ch_en are latched into snapshot registers and busy rises at edge k. The FSM selects the lowest enabled channel.
- No channel enabled: go to DONE. done pulses 1 cycle later and the FSM returns to IDLE with no sync activity.
- SETUP: sync=0, clk_out=1, din=frame MSB; lasts CLK_DIV cycles.
- SHIFT_LO: clk_out=0 for CLK_DIV cycles. The DAC samples on the falling edge.
- SHIFT_HI: clk_out=1 for CLK_DIV cycles. At its end, din advances to the next bit. After bit 0's high phase the FSM goes to GAP.
- GAP: sync=1, din=0 for GAP cycles, then the next enabled channel's SETUP. After the last enabled channel, the FSM goes to DONE.
- Frame length = CLK_DIV + 2*CLK_DIV*FRAME_W + GAP clk cycles (default 136).
- DONE: done=1 for exactly 1 cycle. If cont=1 (sampled in DONE), codes and ch_en are re-latched and the next sweep starts the following cycle with busy held 1. Otherwise busy falls with the DONE->IDLE transition.
- start while busy is ignored. codes, ch_en and cont changes mid-sweep do not affect the current sweep.
- ch_idx updates when SETUP is entered and holds through GAP.
- All outputs are registered; no combinational path from inputs to outputs.
- Dividers and bit counter are sized by $clog2; the bit counter counts FRAME_W-1 down to 0 with no wrap beyond.

Decomposition:
- Package dac_scan_pkg: state enum, FRAME_W function, CMD_BITS default, frame-assembly function.
- Sub-module dac_spi_shifter: one-frame serialiser (SETUP/SHIFT/GAP timing, CLK_DIV divider). Inputs: frame and go. Outputs: din/sync/clk_out and frame_done.
- The top level holds the snapshot registers, channel sequencer, cont/done logic and vdd enables.

Test Plan:
- Reset release, then idle 20 cycles -> vdd1=vdd2=1 one cycle after rst_n rises; sync=1, clk_out=1, din=0, busy=0 throughout.
- ch_en=4'b1111, codes ch0..3 = 12'hABC, 12'h123, 12'hFFF, 12'h000, one start pulse -> 4 frames of 16 falling edges, decoded 16'h1ABC, 16'h5123, 16'h9FFF, 16'hD000. done pulses once, 544 cycles after the start edge, and busy falls with it.
- ch_en=4'b0101 -> only frames for ch0 and ch2 are sent; ch_idx reads 0 then 2; done arrives 272 cycles after start.
- ch_en=0, start -> no sync low; done pulses 1 cycle after start.
- cont=1 for two sweeps with codes changed mid-sweep -> the first sweep carries the old codes and the second the new; busy stays 1 across; 2 done pulses. Clearing cont during sweep 3 ends the run after sweep 3.
- rst_n pulled low in the middle of frame 2 bit 7 -> sync=1, clk_out=1 and vdd low immediately. After release plus a new start, frame 1 is resent complete.

Source files
------------

// File: rtl/dac_scan_pkg.sv
// Shared types and frame helpers for the serial-DAC scan driver.
package dac_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_GAP,
    ST_DONE
  } scan_state_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_DONE
  } seq_state_t;

  localparam logic [1:0] CMD_BITS_DEF = 2'b01;
  localparam int         MAX_FRAME_W  = 32;

  function automatic int frame_w(input int addr_w, input int code_w);
    return addr_w + 2 + code_w;
  endfunction

  // Right-justified {addr, cmd, code}; callers truncate to their own frame width.
  function automatic logic [MAX_FRAME_W-1:0] make_frame(
    input int                     code_w,
    input logic [MAX_FRAME_W-1:0] addr,
    input logic [1:0]             cmd,
    input logic [MAX_FRAME_W-1:0] code
  );
    logic [MAX_FRAME_W-1:0] mask;
    mask = (MAX_FRAME_W'(1) << code_w) - MAX_FRAME_W'(1);
    return (addr << (code_w + 2)) | (MAX_FRAME_W'(cmd) << code_w) | (code & mask);
  endfunction

endpackage

// File: rtl/dac_scan_driver_shifter.sv
// One-frame serialiser: SETUP, FRAME_W low/high clock pairs, then a sync-high gap.
module dac_spi_shifter
  import dac_scan_pkg::*;
#(
  parameter int FRAME_W = 16,
  parameter int CLK_DIV = 4,
  parameter int GAP     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic [FRAME_W-1:0] frame,
  output logic               din,
  output logic               sync,
  output logic               clk_out,
  output logic               frame_done
);

  localparam int CNT_MAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_W);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);
  localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(FRAME_W - 1);

  scan_state_t        state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [BIT_W-1:0]   bit_cnt, bit_nxt;
  logic [FRAME_W-1:0] shreg, shreg_nxt;
  logic               din_nxt, sync_nxt, clk_nxt;
  logic               load;

  // High during the final gap cycle so the next frame can start without a bubble.
  assign frame_done = (state == ST_GAP) && (cnt == GAP_LAST);
  assign load       = go && ((state == ST_IDLE) || frame_done);

  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    din_nxt   = din;
    sync_nxt  = sync;
    clk_nxt   = clk_out;

    unique case (state)
      ST_IDLE: ;
      ST_SETUP: begin
        if (cnt == DIV_LAST) begin
          state_nxt = ST_SHIFT_LO;
          cnt_nxt   = '0;
          clk_nxt   = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_SHIFT_LO: begin
        if (cnt == DIV_LAST) begin
          state_nxt = ST_SHIFT_HI;
          cnt_nxt   = '0;
          clk_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_SHIFT_HI: begin
        if (cnt == DIV_LAST) begin
          cnt_nxt = '0;
          if (bit_cnt == '0) begin
            state_nxt = ST_GAP;
            sync_nxt  = 1'b1;
            din_nxt   = 1'b0;
          end else begin
            state_nxt = ST_SHIFT_LO;
            bit_nxt   = bit_cnt - 1'b1;
            din_nxt   = shreg[bit_cnt - 1'b1];
            clk_nxt   = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (load) begin
      state_nxt = ST_SETUP;
      cnt_nxt   = '0;
      bit_nxt   = BIT_TOP;
      shreg_nxt = frame;
      din_nxt   = frame[FRAME_W-1];
      sync_nxt  = 1'b0;
      clk_nxt   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      din     <= 1'b0;
      sync    <= 1'b1;
      clk_out <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
      din     <= din_nxt;
      sync    <= sync_nxt;
      clk_out <= clk_nxt;
    end
  end

endmodule

// File: rtl/dac_scan_driver.sv
// Multi-channel DAC scan driver: snapshots codes on start and sends one frame per
// enabled channel, lowest index first, in single-sweep or continuous mode.
module dac_scan_driver
  import dac_scan_pkg::*;
#(
  parameter int         N_CH     = 4,
  parameter int         CODE_W   = 12,
  parameter int         ADDR_W   = 2,
  parameter logic [1:0] CMD_BITS = CMD_BITS_DEF,
  parameter int         CLK_DIV  = 4,
  parameter int         GAP      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   cont,
  input  logic [N_CH-1:0]        ch_en,
  input  logic [N_CH*CODE_W-1:0] codes,
  output logic                   din,
  output logic                   sync,
  output logic                   clk_out,
  output logic                   vdd1,
  output logic                   vdd2,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      ch_idx
);

  localparam int FRAME_W = frame_w(ADDR_W, CODE_W);

  seq_state_t             state, state_nxt;
  logic [N_CH*CODE_W-1:0] snap_codes;
  logic [N_CH-1:0]        snap_en;
  logic                   latch, go, use_live, restart;
  logic                   busy_nxt, done_nxt;
  logic [ADDR_W-1:0]      idx_nxt, first_idx, next_idx;
  logic                   any_live, has_next;
  logic [CODE_W-1:0]      sel_code;
  logic [FRAME_W-1:0]     frame;
  logic                   frame_done;

  // First channel of a new sweep comes from the live inputs, since they are
  // latched on the same edge that launches the first frame.
  always_comb begin
    any_live  = |ch_en;
    first_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_en[i]) first_idx = ADDR_W'(i);
    end
    has_next = 1'b0;
    next_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (snap_en[i] && (i > int'(ch_idx))) begin
        has_next = 1'b1;
        next_idx = ADDR_W'(i);
      end
    end
  end

  assign restart = ((state == SEQ_IDLE) && start) || ((state == SEQ_DONE) && cont);

  always_comb begin
    state_nxt = state;
    busy_nxt  = busy;
    idx_nxt   = ch_idx;
    latch     = 1'b0;
    go        = 1'b0;
    use_live  = 1'b0;

    if (restart) begin
      latch     = 1'b1;
      busy_nxt  = 1'b1;
      state_nxt = SEQ_RUN;
      if (any_live) begin
        go       = 1'b1;
        use_live = 1'b1;
        idx_nxt  = first_idx;
      end
    end else begin
      unique case (state)
        SEQ_IDLE: ;
        SEQ_RUN: begin
          if (snap_en == '0) begin
            state_nxt = SEQ_DONE;
          end else if (frame_done) begin
            if (has_next) begin
              go      = 1'b1;
              idx_nxt = next_idx;
            end else begin
              state_nxt = SEQ_DONE;
            end
          end
        end
        SEQ_DONE: begin
          state_nxt = SEQ_IDLE;
          busy_nxt  = 1'b0;
        end
        default: state_nxt = SEQ_IDLE;
      endcase
    end

    done_nxt = (state_nxt == SEQ_DONE);
  end

  assign sel_code = use_live ? codes[int'(idx_nxt)*CODE_W +: CODE_W]
                             : snap_codes[int'(idx_nxt)*CODE_W +: CODE_W];
  assign frame    = FRAME_W'(make_frame(CODE_W, MAX_FRAME_W'(idx_nxt), CMD_BITS,
                                        MAX_FRAME_W'(sel_code)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEQ_IDLE;
      snap_codes <= '0;
      snap_en    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ch_idx     <= '0;
      vdd1       <= 1'b0;
      vdd2       <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      ch_idx <= idx_nxt;
      vdd1   <= 1'b1;
      vdd2   <= 1'b1;
      if (latch) begin
        snap_codes <= codes;
        snap_en    <= ch_en;
      end
    end
  end

  dac_spi_shifter #(
    .FRAME_W (FRAME_W),
    .CLK_DIV (CLK_DIV),
    .GAP     (GAP)
  ) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .frame      (frame),
    .din        (din),
    .sync       (sync),
    .clk_out    (clk_out),
    .frame_done (frame_done)
  );

endmodule

// File: tb/tb_dac_scan_driver.sv
// Scoreboard bench: stimulus queues expected frames and done times, a monitor
// decodes the serial bus and the done pulse and compares against them.
module tb_dac_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic [3:0]  ch_en = '0;
  logic [47:0] codes = '0;
  logic        din, sync, clk_out, vdd1, vdd2, busy, done;
  logic [1:0]  ch_idx;

  always #5 clk = ~clk;

  dac_scan_driver dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .cont    (cont),
    .ch_en   (ch_en),
    .codes   (codes),
    .din     (din),
    .sync    (sync),
    .clk_out (clk_out),
    .vdd1    (vdd1),
    .vdd2    (vdd2),
    .busy    (busy),
    .done    (done),
    .ch_idx  (ch_idx)
  );

  typedef struct packed {
    logic [15:0] frame;
    logic [1:0]  idx;
  } exp_frame_t;

  exp_frame_t exp_frames[$];
  int         exp_done[$];

  int   n_chk = 0, n_bad = 0, cyc = 0;
  int   done_cnt = 0, frame_starts = 0, aborted = 0, bits = 0;
  logic [15:0] sr = '0;
  logic [1:0]  cap_idx = '0;
  logic        in_frame = 1'b0, prev_sync = 1'b1, prev_clk = 1'b1, busy_low_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) begin
      tick();
      if (!busy) busy_low_seen = 1'b1;
    end
  endtask

  task automatic pulse_start(output int k);
    start = 1'b1;
    tick();
    start = 1'b0;
    k = cyc;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check("done_count", 32'(done_cnt), 32'(target));
  endtask

  task automatic set_codes(input logic [11:0] c0, c1, c2, c3);
    codes = {c3, c2, c1, c0};
  endtask

  task automatic push_frame(input logic [15:0] f, input logic [1:0] idx);
    exp_frame_t e;
    e.frame = f;
    e.idx   = idx;
    exp_frames.push_back(e);
  endtask

  // Monitor: decode frames on clk_out falling edges while sync is low.
  initial begin
    exp_frame_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (in_frame) begin
          aborted++;
          in_frame = 1'b0;
        end
      end else begin
        if (prev_sync && !sync) begin
          in_frame = 1'b1;
          frame_starts++;
          bits    = 0;
          sr      = '0;
          cap_idx = ch_idx;
        end else if (in_frame && !sync && prev_clk && !clk_out) begin
          sr = {sr[14:0], din};
          bits++;
        end else if (in_frame && sync) begin
          in_frame = 1'b0;
          if (exp_frames.size() == 0) begin
            n_chk++;
            n_bad++;
            $display("FAIL frame_unexpected: got %h with no frame expected", sr);
          end else begin
            e = exp_frames.pop_front();
            check("frame_data", 32'(sr), 32'(e.frame));
            check("frame_bits", 32'(bits), 32'd16);
            check("frame_ch_idx", 32'(cap_idx), 32'(e.idx));
          end
        end
        if (done) begin
          done_cnt++;
          check("busy_at_done", 32'(busy), 32'd1);
          if (exp_done.size() == 0) begin
            n_chk++;
            n_bad++;
            $display("FAIL done_unexpected: got done at cycle %0d with none expected", cyc);
          end else begin
            check("done_cycle", 32'(cyc), 32'(exp_done.pop_front()));
          end
        end
      end
      prev_sync = sync;
      prev_clk  = clk_out;
    end
  end

  initial begin
    int k, base, fs0;

    // Reset state and supply enables.
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 32'({sync, clk_out, din, busy, done, vdd1, vdd2}), 32'b1100000);
    check("reset_ch_idx", 32'(ch_idx), 32'd0);
    rst_n = 1'b1;
    tick();
    check("vdd_after_reset", 32'({vdd1, vdd2}), 32'b11);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_bus", 32'({sync, clk_out, din, busy}), 32'b1100);
    end

    // Full sweep, all four channels; a second start mid-sweep must be ignored.
    set_codes(12'hABC, 12'h123, 12'hFFF, 12'h000);
    ch_en = 4'b1111;
    push_frame(16'h1ABC, 2'd0);
    push_frame(16'h5123, 2'd1);
    push_frame(16'h9FFF, 2'd2);
    push_frame(16'hD000, 2'd3);
    base = done_cnt;
    pulse_start(k);
    exp_done.push_back(k + 544);
    check("busy_after_start", 32'(busy), 32'd1);
    run_to(k + 100);
    pulse_start(fs0);
    wait_done(base + 1, 700);
    check("busy_after_sweep", 32'(busy), 32'd0);

    // Sparse enable mask.
    ch_en = 4'b0101;
    push_frame(16'h1ABC, 2'd0);
    push_frame(16'h9FFF, 2'd2);
    base = done_cnt;
    pulse_start(k);
    exp_done.push_back(k + 272);
    wait_done(base + 1, 400);
    check("busy_after_sparse", 32'(busy), 32'd0);

    // No channel enabled.
    ch_en = 4'b0000;
    fs0   = frame_starts;
    base  = done_cnt;
    pulse_start(k);
    exp_done.push_back(k + 1);
    wait_done(base + 1, 20);
    check("empty_no_frames", 32'(frame_starts), 32'(fs0));
    check("busy_after_empty", 32'(busy), 32'd0);

    // Continuous mode with codes changed mid-sweep; cont cleared in sweep 3.
    ch_en = 4'b0011;
    cont  = 1'b1;
    set_codes(12'h111, 12'h222, 12'h000, 12'h000);
    push_frame(16'h1111, 2'd0);
    push_frame(16'h5222, 2'd1);
    push_frame(16'h1333, 2'd0);
    push_frame(16'h5444, 2'd1);
    push_frame(16'h1555, 2'd0);
    push_frame(16'h5666, 2'd1);
    base = done_cnt;
    pulse_start(k);
    exp_done.push_back(k + 272);
    exp_done.push_back(k + 545);
    exp_done.push_back(k + 818);
    busy_low_seen = 1'b0;
    run_to(k + 50);
    set_codes(12'h333, 12'h444, 12'h000, 12'h000);
    run_to(k + 400);
    set_codes(12'h555, 12'h666, 12'h000, 12'h000);
    run_to(k + 600);
    cont = 1'b0;
    set_codes(12'h777, 12'h888, 12'h000, 12'h000);
    run_to(k + 818);
    check("busy_held_cont", 32'(busy_low_seen), 32'd0);
    wait_done(base + 3, 50);
    check("busy_after_cont", 32'(busy), 32'd0);
    fs0 = frame_starts;
    repeat (300) tick();
    check("cont_stopped_done", 32'(done_cnt), 32'(base + 3));
    check("cont_stopped_frames", 32'(frame_starts), 32'(fs0));

    // Reset in frame 2, bit 7, then a clean resend of frame 1.
    ch_en = 4'b1111;
    set_codes(12'hABC, 12'h123, 12'hFFF, 12'h000);
    push_frame(16'h1ABC, 2'd0);
    pulse_start(k);
    run_to(k + 206);
    check("bits_before_reset", 32'(bits), 32'd9);
    #1 rst_n = 1'b0;
    #1;
    check("abort_outputs", 32'({sync, clk_out, din, busy, vdd1, vdd2}), 32'b110000);
    repeat (3) tick();
    check("abort_counted", 32'(aborted), 32'd1);
    rst_n = 1'b1;
    tick();
    check("vdd_after_rerelease", 32'({vdd1, vdd2}), 32'b11);
    ch_en = 4'b0001;
    push_frame(16'h1ABC, 2'd0);
    base = done_cnt;
    pulse_start(k);
    exp_done.push_back(k + 136);
    wait_done(base + 1, 200);

    tick();
    check("frames_left", 32'(exp_frames.size()), 32'd0);
    check("dones_left", 32'(exp_done.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
